// File: rtl/seq_mag_comp_pkg.sv
// seq_mag_comp_pkg: FSM encoding and sizing helpers shared by the sequential magnitude comparator.
package seq_mag_comp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int num_slices(input int w, input int s);
        return w / s;
    endfunction

    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic bit slicing_ok(input int w, input int s);
        return s >= 1 && w >= s && (w % s) == 0;
    endfunction

endpackage

// File: rtl/seq_mag_comp_cmp_slice.sv
// seq_mag_comp_cmp_slice: combinational unsigned comparator for one SLICE-bit slice.
module seq_mag_comp_cmp_slice #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o
);

    assign gt_o = a_i > b_i;
    assign eq_o = a_i == b_i;

endmodule

// File: rtl/seq_mag_comp.sv
// seq_mag_comp: compares two W-bit operands SLICE bits per clock, MSB slice first,
// stopping at the first unequal slice; signed mode flips both sign bits at latch time.
module seq_mag_comp
    import seq_mag_comp_pkg::*;
#(
    parameter int W     = 8,
    parameter int SLICE = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done_tick,
    output logic         agtb,
    output logic         aeqb,
    output logic         altb
);

    localparam int N  = num_slices(W, SLICE);
    localparam int IW = idx_width(N);
    localparam logic [W-1:0] MSB = W'(1) << (W - 1);

    if (!slicing_ok(W, SLICE)) begin : g_bad_slice
        $error("seq_mag_comp: W must be a positive multiple of SLICE");
    end

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [2:0]     flags_q, flags_d;
    logic [SLICE-1:0] a_sl, b_sl;
    logic           sl_gt, sl_eq;

    assign a_sl = a_q[idx_q*SLICE +: SLICE];
    assign b_sl = b_q[idx_q*SLICE +: SLICE];

    seq_mag_comp_cmp_slice #(.SLICE(SLICE)) u_cmp_slice (
        .a_i (a_sl),
        .b_i (b_sl),
        .gt_o(sl_gt),
        .eq_o(sl_eq)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE: if (start) begin
                a_d     = a ^ (signed_mode ? MSB : '0);
                b_d     = b ^ (signed_mode ? MSB : '0);
                idx_d   = IW'(N - 1);
                state_d = RUN;
            end
            RUN: if (!sl_eq || idx_q == '0) begin
                flags_d = {sl_gt, sl_eq, !sl_gt && !sl_eq};
                state_d = DONE;
            end else begin
                idx_d = idx_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            flags_q <= flags_d;
        end
    end

    assign ready              = state_q == IDLE;
    assign done_tick          = state_q == DONE;
    assign {agtb, aeqb, altb} = flags_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// tb_seq_mag_comp: directed table plus corner sequences; three W=8 slicings and one W=32 run in parallel.
module tb_seq_mag_comp;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        int         lat;
        logic [2:0] f;
    } vec_t;

    localparam int WA [4] = '{8, 8, 8, 32};
    localparam int SA [4] = '{2, 1, 8, 4};

    logic        clk = 1'b0;
    logic        reset, start, sm;
    logic [7:0]  a, b;
    logic [31:0] a32, b32;
    logic [3:0]  rdy, dn, gt, eq, lt;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    always #5 clk = ~clk;

    seq_mag_comp #(.W(8), .SLICE(2)) u0 (
        .clk(clk), .reset(reset), .start(start), .signed_mode(sm), .a(a), .b(b),
        .ready(rdy[0]), .done_tick(dn[0]), .agtb(gt[0]), .aeqb(eq[0]), .altb(lt[0]));
    seq_mag_comp #(.W(8), .SLICE(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .signed_mode(sm), .a(a), .b(b),
        .ready(rdy[1]), .done_tick(dn[1]), .agtb(gt[1]), .aeqb(eq[1]), .altb(lt[1]));
    seq_mag_comp #(.W(8), .SLICE(8)) u2 (
        .clk(clk), .reset(reset), .start(start), .signed_mode(sm), .a(a), .b(b),
        .ready(rdy[2]), .done_tick(dn[2]), .agtb(gt[2]), .aeqb(eq[2]), .altb(lt[2]));
    seq_mag_comp #(.W(32), .SLICE(4)) u3 (
        .clk(clk), .reset(reset), .start(start), .signed_mode(sm), .a(a32), .b(b32),
        .ready(rdy[3]), .done_tick(dn[3]), .agtb(gt[3]), .aeqb(eq[3]), .altb(lt[3]));

    task automatic chk(input string nm, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y, input int w, input int s);
        for (int k = 1; k <= w / s; k++)
            if (((x ^ y) >> (w - k * s)) != 0) return k;
        return w / s;
    endfunction

    function automatic logic [2:0] ref_flags(input logic [31:0] x, input logic [31:0] y, input int w, input logic s);
        logic signed [32:0] xs, ys;
        xs = {1'b0, x};
        ys = {1'b0, y};
        if (s) begin
            xs = (xs <<< (33 - w)) >>> (33 - w);
            ys = (ys <<< (33 - w)) >>> (33 - w);
        end
        return {xs > ys, xs == ys, xs < ys};
    endfunction

    task automatic run(input logic [7:0] va, input logic [7:0] vb, input logic [31:0] wa, input logic [31:0] wb,
                       input logic vs, input int lat0, input logic [2:0] f0, input string nm);
        int lat [4];
        int ticks [4];
        logic [31:0] xa, xb;
        for (int i = 0; i < 4; i++) begin
            lat[i]   = -1;
            ticks[i] = 0;
        end
        @(negedge clk);
        a = va; b = vb; a32 = wa; b32 = wb; sm = vs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~va; b = ~vb; a32 = ~wa; b32 = ~wb; sm = ~vs;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (dn[i]) begin
                ticks[i]++;
                if (lat[i] < 0) lat[i] = k;
            end
        end
        for (int i = 0; i < 4; i++) begin
            xa = i == 3 ? wa : {24'b0, va};
            xb = i == 3 ? wb : {24'b0, vb};
            chk($sformatf("%s u%0d lat", nm, i), lat[i],
                (i == 0 && lat0 > 0) ? lat0 : ref_lat(xa, xb, WA[i], SA[i]));
            chk($sformatf("%s u%0d ticks", nm, i), ticks[i], 1);
            chk($sformatf("%s u%0d flags", nm, i), int'({gt[i], eq[i], lt[i]}),
                int'((i == 0 && lat0 > 0) ? f0 : ref_flags(xa, xb, WA[i], vs)));
        end
        chk($sformatf("%s ready", nm), int'(rdy), 4'hF);
    endtask

    initial begin
        vec_t tbl [11];
        int   ticks;
        logic [7:0] ra, rb;
        logic [31:0] rwa, rwb;
        tbl[0]  = '{8'hB4, 8'hB1, 1'b0, 3, 3'b100};
        tbl[1]  = '{8'h5A, 8'h5A, 1'b0, 4, 3'b010};
        tbl[2]  = '{8'h5A, 8'h5A, 1'b1, 4, 3'b010};
        tbl[3]  = '{8'h80, 8'h01, 1'b0, 1, 3'b100};
        tbl[4]  = '{8'h80, 8'h01, 1'b1, 1, 3'b001};
        tbl[5]  = '{8'h00, 8'hFF, 1'b0, 1, 3'b001};
        tbl[6]  = '{8'hFF, 8'h00, 1'b1, 1, 3'b001};
        tbl[7]  = '{8'h7F, 8'h80, 1'b1, 1, 3'b100};
        tbl[8]  = '{8'h03, 8'h02, 1'b0, 4, 3'b100};
        tbl[9]  = '{8'hFE, 8'hFF, 1'b1, 4, 3'b001};
        tbl[10] = '{8'h12, 8'h21, 1'b0, 2, 3'b001};
        reset = 1'b1; start = 1'b0; sm = 1'b0;
        a = '0; b = '0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", int'(rdy), 4'hF);
        chk("reset done", int'(dn), 0);
        chk("reset flags", int'({gt, eq, lt}), 0);
        @(negedge clk);
        reset = 1'b0;
        // Busy-time start pulse with swapped operands must be dropped, not queued.
        @(negedge clk);
        a = 8'h00; b = 8'hFF; a32 = '0; b32 = '0; sm = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'h00;
        ticks = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 2) start = 1'b0;
            if (dn[0]) ticks++;
        end
        chk("ignored start ticks", ticks, 1);
        chk("ignored start flags", int'({gt[0], eq[0], lt[0]}), 3'b001);
        chk("ignored start ready", int'(rdy), 4'hF);
        // Reset in the middle of an equal-operand compare aborts it silently.
        @(negedge clk);
        a = 8'h5A; b = 8'h5A; a32 = 32'hCAFE_F00D; b32 = 32'hCAFE_F00D; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid-run busy", int'(rdy[0]), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort ready", int'(rdy), 4'hF);
        chk("abort flags", int'({gt, eq, lt}), 0);
        chk("abort done", int'(dn), 0);
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (dn != 0) ticks++;
        end
        chk("abort no tick", ticks, 0);
        for (int i = 0; i < 11; i++)
            run(tbl[i].a, tbl[i].b, {4{tbl[i].a}}, {4{tbl[i].b}}, tbl[i].sm, tbl[i].lat, tbl[i].f,
                $sformatf("vec%0d", i));
        for (int i = 0; i < 20; i++) begin
            ra  = 8'($urandom);
            rb  = (i % 4 == 0) ? ra : 8'($urandom);
            rwa = $urandom;
            rwb = (i % 3 == 0) ? rwa ^ (32'd1 << $urandom_range(31)) : (i % 5 == 0 ? rwa : $urandom);
            run(ra, rb, rwa, rwb, 1'($urandom_range(1)), -1, 3'b000, $sformatf("rnd%0d", i));
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
Parametrised sequential magnitude comparator for two W-bit operands. Compares SLICE bits per clock, MSB slice first, and stops early at the first unequal slice. Supports unsigned and two's-complement signed modes and produces one-hot gt/eq/lt flags. Sits beside the datapath as a shared compare unit, using a start/ready/done_tick handshake.

Parameters:
W, 8, operand width in bits; must be a multiple of SLICE and at least SLICE.
SLICE, 2, bits compared per cycle; 1 <= SLICE <= W.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a compare; sampled only when ready=1.
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with start.
a  input  W  operand A; latched on an accepted start.
b  input  W  operand B; latched on an accepted start.
ready  output  1  1 in IDLE only.
done_tick  output  1  one-cycle pulse when a result is valid.
agtb  output  1  result A > B.
aeqb  output  1  result A == B.
altb  output  1  result A < B.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - state=IDLE; ready=1; done_tick=0; agtb=aeqb=altb=0.
  - Latched operands and the slice index are cleared.
  - Reset overrides any other event in the same cycle, including mid-RUN; no done_tick is produced for an aborted compare.
- Let N=W/SLICE. Slices are indexed N-1 (MSBs) down to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1 at the edge: latch a, b and signed_mode; idx<=N-1; go to RUN.
  - In signed mode, invert bit W-1 of both latched operands at the latch edge. This reduces signed compare to unsigned.
- RUN:
  - ready=0. Compare slice idx of the latched A and B combinationally.
  - If slice A > slice B: agtb<=1, aeqb<=0, altb<=0; go to DONE.
  - If slice A < slice B: altb<=1, others 0; go to DONE.
  - If the slices are equal and idx==0: aeqb<=1, others 0; go to DONE.
  - If the slices are equal and idx>0: idx<=idx-1; stay in RUN.
- DONE:
  - done_tick=1 for exactly this cycle; ready=0. Go to IDLE next edge.
- Result flags:
  - Update only on the RUN->DONE edge.
  - Hold until the next RUN->DONE edge or reset.
  - Exactly one flag is high after the first completion.
- Latency (accepted start edge = edge 0):
  - Differing slice found at the k-th compared slice (k=1..N): done_tick high in the cycle after edge k.
  - Worst case (equal operands) is N.
  - Minimum start-to-start throughput is k+2 cycles.
- Boundary conditions:
  - start while ready=0 is ignored, not queued.
  - Operand or mode changes after the latch edge have no effect.
  - SLICE=W gives a single RUN cycle.
  - idx never underflows.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE/RUN/DONE;
  - N=W/SLICE;
  - idx width = clog2(N), minimum 1;
  - a compile-time check that W % SLICE == 0.
- One sub-module: cmp_slice, a combinational SLICE-bit comparator with gt and eq outputs.
  - The top muxes slice idx into cmp_slice and holds the FSM, index counter and result registers.

Test Plan:
- W=8, SLICE=2, unsigned, a=0xB4, b=0xB1 -> slices 3 and 2 equal, slice 1 decides; done_tick in cycle after edge 3; agtb=1, aeqb=0, altb=0.
- W=8, SLICE=2, unsigned, a=b=0x5A -> done_tick after edge 4 (N=4); aeqb=1 only. Repeat with signed_mode=1 -> same result.
- W=8, SLICE=2, a=0x80, b=0x01: unsigned -> agtb=1 after edge 1; signed -> altb=1 after edge 1 (-128 < 1).
- Start a=0x00, b=0xFF; pulse start again with a=0xFF, b=0x00 while ready=0 -> second start ignored; single done_tick with altb=1; ready returns 1 after DONE.
- Assert reset during RUN of an equal-operand compare -> next cycle ready=1, all flags 0, no done_tick. A fresh start then completes normally.
- Parameter sweep: W=8/SLICE=1, W=8/SLICE=8, W=32/SLICE=4. Random signed and unsigned operands checked against a reference compare; latency equals the first-differing-slice position, or N when operands are equal.
